// File: rtl/fifo_control_unit_pkg.sv
// Shared FIFO constants and the pointer type used by the controller, the register file and the wrappers.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_AF_LEVEL   = 12;
    localparam int FIFO_AE_LEVEL   = 2;

    typedef logic [FIFO_ADDR_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/fifo_control_unit_if.sv
// Producer/consumer handshake and storage-control bundle for the FIFO controller.
// Optional level flags appear only when FIFO_LEVEL_FLAGS_EN is defined.
interface fifo_control_unit_if
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);

    // push/pop are requests sampled every rising edge; there is no ready back-pressure,
    // a request made against full/empty is dropped and reported by overflow/underflow.
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  we;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
`ifdef FIFO_LEVEL_FLAGS_EN
    logic                  almost_full;
    logic                  almost_empty;

    modport master (
        output push, pop,
        input  w_addr, r_addr, we, full, empty, overflow, underflow, almost_full, almost_empty
    );

    modport slave (
        input  push, pop,
        output w_addr, r_addr, we, full, empty, overflow, underflow, almost_full, almost_empty
    );
`else
    modport master (
        output push, pop,
        input  w_addr, r_addr, we, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop,
        output w_addr, r_addr, we, full, empty, overflow, underflow
    );
`endif

endinterface

// File: rtl/fifo_control_unit.sv
// Pointer/flag controller turning a 2**ADDR_WIDTH-entry register file into a FIFO.
// Define FIFO_LEVEL_FLAGS_EN to add the occupancy counter and almost_full/almost_empty.
module fifo_control_unit
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
`ifdef FIFO_LEVEL_FLAGS_EN
    ,
    parameter int AF_LEVEL   = FIFO_AF_LEVEL,
    parameter int AE_LEVEL   = FIFO_AE_LEVEL
`endif
) (
    input logic               clk,
    input logic               rst,
    fifo_control_unit_if.slave bus
);

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, wptr_inc;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d, rptr_inc;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok, rd_ok;

    // A pop frees the slot on the same edge, so a push into a full FIFO is accepted alongside it.
    assign wr_ok    = bus.push & (~full_q | bus.pop);
    assign rd_ok    = bus.pop & ~empty_q;
    assign wptr_inc = wptr_q + 1'b1;
    assign rptr_inc = rptr_q + 1'b1;

    always_comb begin
        wptr_d      = wr_ok ? wptr_inc : wptr_q;
        rptr_d      = rd_ok ? rptr_inc : rptr_q;
        full_d      = full_q;
        empty_d     = empty_q;
        overflow_d  = bus.push & full_q & ~bus.pop;
        underflow_d = bus.pop & empty_q;
        if (wr_ok && !rd_ok) begin
            empty_d = 1'b0;
            full_d  = (wptr_inc == rptr_q);
        end else if (rd_ok && !wr_ok) begin
            full_d  = 1'b0;
            empty_d = (rptr_inc == wptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.w_addr    = wptr_q;
    assign bus.r_addr    = rptr_q;
    assign bus.we        = wr_ok;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

`ifdef FIFO_LEVEL_FLAGS_EN
    localparam logic [ADDR_WIDTH:0] AF_CNT = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                afull_q, aempty_q;

    always_comb begin
        unique case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Level flags are registered from the next count so they line up with full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            count_q  <= count_d;
            afull_q  <= (count_d >= AF_CNT);
            aempty_q <= (count_d <= AE_CNT);
        end
    end

    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
`endif

endmodule

// File: tb/tb_fifo_control_unit.sv
// Directed bench for fifo_control_unit with a behavioural register file and an expected-data queue.
// Level-flag checks are compiled in when FIFO_LEVEL_FLAGS_EN is defined.
module tb_fifo_control_unit;
    import fifo_pkg::*;

    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;

    logic clk;
    logic rst;
    logic [FIFO_DATA_WIDTH-1:0] wdata;
    logic [FIFO_DATA_WIDTH-1:0] mem [DEPTH];

    int n_tests;
    int n_fail;

    // Reference model: occupancy, expected pointers, expected data order.
    int   model_cnt;
    ptr_t exp_w;
    ptr_t exp_r;
    logic [FIFO_DATA_WIDTH-1:0] exp_q[$];

    fifo_control_unit_if #(.ADDR_WIDTH(FIFO_ADDR_WIDTH)) bus ();

    fifo_control_unit #(.ADDR_WIDTH(FIFO_ADDR_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and register-file storage.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.we) mem[bus.w_addr] <= wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic exp_ovf, input logic exp_unf);
        check({tag, ":full"},      32'(bus.full),      32'(model_cnt == DEPTH));
        check({tag, ":empty"},     32'(bus.empty),     32'(model_cnt == 0));
        check({tag, ":overflow"},  32'(bus.overflow),  32'(exp_ovf));
        check({tag, ":underflow"}, 32'(bus.underflow), 32'(exp_unf));
`ifdef FIFO_LEVEL_FLAGS_EN
        check({tag, ":almost_full"},  32'(bus.almost_full),  32'(model_cnt >= FIFO_AF_LEVEL));
        check({tag, ":almost_empty"}, 32'(bus.almost_empty), 32'(model_cnt <= FIFO_AE_LEVEL));
`endif
    endtask

    // One clock of push/pop; checks we/addresses/read data before the edge, flags after it.
    task automatic op(input string tag, input logic p, input logic q, input logic [7:0] d);
        logic exp_wr, exp_rd, exp_ovf, exp_unf;
        logic [7:0] exp_d;
        @(negedge clk);
        bus.push = p;
        bus.pop  = q;
        wdata    = d;
        exp_wr   = p && (model_cnt < DEPTH || q);
        exp_rd   = q && (model_cnt > 0);
        exp_ovf  = p && !q && (model_cnt == DEPTH);
        exp_unf  = q && (model_cnt == 0);
        #1;
        check({tag, ":we"},     32'(bus.we),     32'(exp_wr));
        check({tag, ":w_addr"}, 32'(bus.w_addr), 32'(exp_w));
        check({tag, ":r_addr"}, 32'(bus.r_addr), 32'(exp_r));
        if (exp_rd) begin
            exp_d = exp_q.pop_front();
            check({tag, ":rdata"}, 32'(mem[bus.r_addr]), 32'(exp_d));
        end
        @(posedge clk);
        #1;
        if (exp_wr) begin
            exp_q.push_back(d);
            exp_w = exp_w + 1'b1;
        end
        if (exp_rd) exp_r = exp_r + 1'b1;
        model_cnt = model_cnt + int'(exp_wr) - int'(exp_rd);
        check_flags(tag, exp_ovf, exp_unf);
    endtask

    task automatic reset_during_push();
        @(negedge clk);
        rst      = 1'b1;
        bus.push = 1'b1;
        bus.pop  = 1'b0;
        wdata    = 8'hEE;
        @(posedge clk);
        #1;
        model_cnt = 0;
        exp_w     = '0;
        exp_r     = '0;
        exp_q.delete();
        check("rst_mid:w_addr", 32'(bus.w_addr), 32'd0);
        check("rst_mid:r_addr", 32'(bus.r_addr), 32'd0);
        check_flags("rst_mid", 1'b0, 1'b0);
        rst      = 1'b0;
        bus.push = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        model_cnt = 0;
        exp_w     = '0;
        exp_r     = '0;
        rst       = 1'b1;
        bus.push  = 1'b0;
        bus.pop   = 1'b0;
        wdata     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset:w_addr", 32'(bus.w_addr), 32'd0);
        check("reset:r_addr", 32'(bus.r_addr), 32'd0);
        check("reset:empty",  32'(bus.empty),  32'd1);
        check("reset:full",   32'(bus.full),   32'd0);
        check_flags("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // 1: fill with 0x00..0x0F
        for (int i = 0; i < DEPTH; i++) op("fill", 1'b1, 1'b0, 8'(i));
        check("fill:full_after16", 32'(bus.full), 32'd1);

        // 2: push into full is rejected, overflow pulses once
        op("ovf", 1'b1, 1'b0, 8'hAA);
        check("ovf:w_addr_held", 32'(bus.w_addr), 32'd0);
        op("ovf_idle", 1'b0, 1'b0, 8'h00);

        // 3: drain, then one extra pop underflows
        for (int i = 0; i < DEPTH; i++) op("drain", 1'b0, 1'b1, 8'h00);
        check("drain:empty_after16", 32'(bus.empty), 32'd1);
        op("unf", 1'b0, 1'b1, 8'h00);
        op("unf_idle", 1'b0, 1'b0, 8'h00);

        // 4: push+pop while empty: only the write lands (pop still flags underflow)
        op("pp_empty", 1'b1, 1'b1, 8'h55);
        check("pp_empty:r_addr", 32'(bus.r_addr), 32'd0);
        check("pp_empty:empty",  32'(bus.empty),  32'd0);

        // 5: top up to full, then push+pop together while full
        for (int i = 1; i < DEPTH; i++) op("topup", 1'b1, 1'b0, 8'(8'h60 + i));
        op("pp_full", 1'b1, 1'b1, 8'h77);
        check("pp_full:full",   32'(bus.full),   32'd1);
        check("pp_full:w_addr", 32'(bus.w_addr), 32'd1);
        check("pp_full:r_addr", 32'(bus.r_addr), 32'd1);
        for (int i = 0; i < DEPTH; i++) op("drain2", 1'b0, 1'b1, 8'h00);

        // 6: interleaved traffic wrapping both pointers, then reset at 5 entries
        for (int k = 0; k < 40; k++)
            op("mix", (k % 4) != 3, (k % 4) != 0, 8'(8'h80 + k));
        while (model_cnt > 0) op("mix_drain", 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) op("five", 1'b1, 1'b0, 8'(8'hA0 + i));
        reset_during_push();
        op("post_rst", 1'b0, 1'b0, 8'h00);
        op("post_rst_push", 1'b1, 1'b0, 8'h3C);
        op("post_rst_pop", 1'b0, 1'b1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
